// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   MEM-stage memory controller. Accepts one load/store per request, optionally
//   fetching a pointer first (LDI/STI), drives the data-cache handshake and
//   stalls the pipeline until the access completes.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   valid             MEM-stage instruction valid
//   mem_read/write    control-word access request (write wins if both set)
//   indirect          fetch pointer at addr first, then access the pointer
//   mem_byte_enable   control-word byte enables
//   addr, wdata       effective address and store data from EX
//   dmem_resp/rdata   data-cache completion and read data
//   dmem_read/write   data-cache strobes (never both high)
//   dmem_address      data-cache address
//   dmem_byte_enable  data-cache byte enables
//   dmem_wdata        data-cache write data
//   stall             hold pipeline registers while an access is outstanding
//   rdata             final load data to WB, held until the next load completes
//   done              one-cycle completion pulse
module mem_stage_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             indirect,
  input  logic [1:0]       mem_byte_enable,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             dmem_resp,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [WIDTH-1:0] dmem_address,
  output logic [1:0]       dmem_byte_enable,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic             stall,
  output logic [WIDTH-1:0] rdata,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle,
    StInd,
    StAccess,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [1:0]       r_be;
  logic             r_rd;
  logic             r_wr;
  logic [WIDTH-1:0] r_rdata;
  logic             w_req;
  logic             w_capture;

  assign w_req     = valid & (mem_read | mem_write);
  assign w_capture = (r_state == StIdle) & w_req;

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_req) w_state_d = indirect ? StInd : StAccess;
      StInd:    if (dmem_resp) w_state_d = StAccess;
      StAccess: if (dmem_resp) w_state_d = StDone;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Operation capture; the pointer fetched in IND replaces the captured address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_be    <= mem_byte_enable;
      // Read+write together degrades to a write only.
      r_rd    <= mem_read & ~mem_write;
      r_wr    <= mem_write;
    end else if ((r_state == StInd) && dmem_resp) begin
      r_addr <= dmem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if ((r_state == StAccess) && dmem_resp && r_rd) begin
      r_rdata <= dmem_rdata;
    end
  end

  // Outputs
  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = r_addr;
    dmem_byte_enable = r_be;
    dmem_wdata       = r_wdata;
    stall            = 1'b0;
    done             = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Combinational so the pipeline freezes in the same cycle as the request.
        stall = w_req;
      end
      StInd: begin
        dmem_read        = 1'b1;
        dmem_byte_enable = 2'b11;
        stall            = 1'b1;
      end
      StAccess: begin
        dmem_write = r_wr;
        dmem_read  = r_rd & ~r_wr;
        stall      = 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign rdata = r_rdata;

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data and address width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port valid  input  1  MEM-stage instruction valid.
REQ-005 SHALL have port mem_read  input  1  control-word read request.
REQ-006 SHALL have port mem_write  input  1  control-word write request.
REQ-007 SHALL have port indirect  input  1  LDI/STI: fetch pointer first.
REQ-008 SHALL have port mem_byte_enable  input  2  control-word byte enables.
REQ-009 SHALL have port addr  input  WIDTH  effective address from the EX stage.
REQ-010 SHALL have port wdata  input  WIDTH  store data.
REQ-011 SHALL have port dmem_resp  input  1  data-cache access complete.
REQ-012 SHALL have port dmem_rdata  input  WIDTH  data-cache read data.
REQ-013 SHALL have port dmem_read  output  1  cache read strobe.
REQ-014 SHALL have port dmem_write  output  1  cache write strobe.
REQ-015 SHALL have port dmem_address  output  WIDTH  cache address.
REQ-016 SHALL have port dmem_byte_enable  output  2  cache byte enables.
REQ-017 SHALL have port dmem_wdata  output  WIDTH  cache write data.
REQ-018 SHALL have port stall  output  1  hold all pipeline control/data registers (load low).
REQ-019 SHALL have port rdata  output  WIDTH  final load data to the WB stage.
REQ-020 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-021 SHALL implement the FSM states IDLE, IND, ACCESS and DONE.
REQ-022 SHALL treat a cycle with valid=1 and (mem_read|mem_write)=1 as a request.
REQ-023 IDLE, request, indirect=1 -> IND; request, indirect=0 -> ACCESS; else stay IDLE.
REQ-024 SHALL capture addr, wdata, mem_byte_enable, mem_read and mem_write into internal registers on the IDLE exit edge; later input changes SHALL NOT affect the operation in flight.
REQ-025 In IND: dmem_read=1, dmem_address=captured addr, dmem_byte_enable=2'b11.
REQ-026 In IND, on dmem_resp=1: capture dmem_rdata as the new captured address, then -> ACCESS.
REQ-027 In ACCESS: drive dmem_read or dmem_write per the captured op, using the captured address, byte enables and wdata.
REQ-028 In ACCESS, on dmem_resp=1: for a read, load rdata from dmem_rdata; then -> DONE.
REQ-029 In DONE: done=1, stall=0, no dmem strobe; -> IDLE unconditionally.
REQ-030 stall SHALL equal (IDLE and request) or IND or ACCESS; it is combinational from the inputs in IDLE.
REQ-031 If mem_read and mem_write are both 1, SHALL perform a write only; dmem_read SHALL stay 0.
REQ-032 SHALL never assert dmem_read and dmem_write together.
REQ-033 When not in IND or ACCESS, dmem_read=dmem_write=0; dmem_address, dmem_byte_enable and dmem_wdata SHALL hold the captured values.
REQ-034 SHALL ignore dmem_resp outside IND and ACCESS.
REQ-035 rdata SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-036 A new request seen in IDLE on the cycle after DONE SHALL start without an idle bubble.
REQ-037 Wait time for dmem_resp SHALL be unbounded, with stall held high throughout.

Reset
REQ-038 reset=1 SHALL force IDLE immediately, independent of clk.
REQ-039 reset=1 SHALL clear rdata, the captured registers and done to 0, and drop dmem_read/dmem_write within the same cycle.
REQ-040 Reset asserted during IND or ACCESS SHALL abandon the access; a dmem_resp arriving after reset release SHALL be ignored.

Verification
REQ-041 LDR: addr=0x1000, mem_read=1, resp after 3 cycles with 0xBEEF -> stall high 4 cycles, then done pulses and rdata=0xBEEF.
REQ-042 STB: addr=0x2001, be=2'b10, wdata=0x5A00 -> dmem_write=1 with address 0x2001 and be 2'b10 until resp; rdata unchanged.
REQ-043 LDI: addr=0x3000, first resp 0x4000, second resp 0x1234 -> second read at address 0x4000; rdata=0x1234; be=2'b11 on both reads.
REQ-044 STI: pointer read returns 0x5000 -> write to 0x5000 with the captured wdata; exactly one read then one write.
REQ-045 Reset mid-ACCESS: dmem_read drops in the reset cycle; state=IDLE; a late resp does not pulse done.
REQ-046 Back-to-back loads: second request present in the cycle after DONE -> it enters ACCESS with no extra cycle; addr changes during the first load do not affect it.
